// File: rtl/fetch_pkg.sv
// Shared types and constants for the IF stage and its IF/ID pipeline register.
package fetch_pkg;

  localparam int unsigned PC_WIDTH    = 16;
  localparam int unsigned INSTR_WIDTH = 16;
  localparam int unsigned OPCODE_MSB  = 15;
  localparam int unsigned OPCODE_LSB  = 11;
  localparam int unsigned FUNC_MSB    = 1;
  localparam int unsigned FUNC_LSB    = 0;
  localparam int unsigned OP_W        = OPCODE_MSB - OPCODE_LSB + 1;
  localparam int unsigned FUNC_W      = FUNC_MSB - FUNC_LSB + 1;

  // 0x0000 decodes as HALT, so bubbles must use this encoding
  localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = 16'h0800;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_WAIT,
    ST_HOLD,
    ST_DROP,
    ST_HALTED
  } fetch_state_e;

  typedef struct packed {
    logic [INSTR_WIDTH-1:0] instr;
    logic [PC_WIDTH-1:0]    pc_plus2;
    logic                   valid;
  } ifid_t;

  function automatic logic [PC_WIDTH-1:0] pc_inc(input logic [PC_WIDTH-1:0] pc);
    return PC_WIDTH'(pc + PC_WIDTH'(2));
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch-stage boundary: hazard/EX/ID controls, instruction memory bus and IF/ID outputs.
interface fetch_if;
  import fetch_pkg::*;

  logic                   stall;
  logic                   redirect_en;
  logic [PC_WIDTH-1:0]    redirect_pc;
  logic                   halt;
  logic                   imem_req;
  logic [PC_WIDTH-1:0]    imem_addr;
  logic                   imem_valid;
  logic [INSTR_WIDTH-1:0] imem_rdata;
  logic [INSTR_WIDTH-1:0] instr_out;
  logic [OP_W-1:0]        I_op;
  logic [FUNC_W-1:0]      func;
  logic [PC_WIDTH-1:0]    pc_plus2_out;
  logic                   valid_out;
  logic                   halted;

  modport master (
    input  stall, redirect_en, redirect_pc, halt, imem_valid, imem_rdata,
    output imem_req, imem_addr, instr_out, I_op, func, pc_plus2_out, valid_out, halted
  );

  modport slave (
    output stall, redirect_en, redirect_pc, halt, imem_valid, imem_rdata,
    input  imem_req, imem_addr, instr_out, I_op, func, pc_plus2_out, valid_out, halted
  );

endinterface

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: flush-to-NOP beats load; otherwise contents are held.
module ifid_reg
  import fetch_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load_i,
  input  logic                   flush_i,
  input  logic [INSTR_WIDTH-1:0] instr_i,
  input  logic [PC_WIDTH-1:0]    pc_plus2_i,
  output ifid_t                  ifid_o
);

  ifid_t ifid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid_q <= '{instr: NOP_INSTR, pc_plus2: '0, valid: 1'b0};
    end else if (flush_i) begin
      ifid_q <= '{instr: NOP_INSTR, pc_plus2: '0, valid: 1'b0};
    end else if (load_i) begin
      ifid_q <= '{instr: instr_i, pc_plus2: pc_plus2_i, valid: 1'b1};
    end
  end

  assign ifid_o = ifid_q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, keeps one fetch outstanding, and fills the IF/ID register.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [PC_WIDTH-1:0] RESET_PC = 16'h0000
) (
  input  logic      clk,
  input  logic      rst,
  fetch_if.master   bus
);

  fetch_state_e           state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] hold_q, hold_d;
  logic                   halted_q;
  logic                   req_c;
  logic                   halt_go;
  logic                   ifid_load;
  logic                   ifid_flush;
  logic [INSTR_WIDTH-1:0] ifid_instr;
  ifid_t                  ifid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_FETCH;
      pc_q     <= RESET_PC;
      hold_q   <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      hold_q   <= hold_d;
      halted_q <= (state_d == ST_HALTED);
    end
  end

  // Priority: redirect, then halt, then the per-state memory handshake
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    hold_d     = hold_q;
    req_c      = 1'b0;
    ifid_load  = 1'b0;
    ifid_flush = 1'b0;
    ifid_instr = bus.imem_rdata;
    halt_go    = bus.halt & ifid.valid & ~bus.redirect_en;

    if (state_q != ST_HALTED) begin
      if (bus.redirect_en) begin
        pc_d       = bus.redirect_pc;
        ifid_flush = 1'b1;
        // a response still in flight must be swallowed before refetching
        state_d    = ((state_q == ST_WAIT || state_q == ST_DROP) && !bus.imem_valid)
                     ? ST_DROP : ST_FETCH;
      end else if (halt_go) begin
        state_d    = ST_HALTED;
        ifid_flush = ~bus.stall;
      end else begin
        case (state_q)
          ST_FETCH: begin
            req_c   = 1'b1;
            state_d = ST_WAIT;
          end
          ST_WAIT: begin
            if (bus.imem_valid) begin
              if (bus.stall) begin
                hold_d  = bus.imem_rdata;
                state_d = ST_HOLD;
              end else begin
                ifid_load = 1'b1;
                pc_d      = pc_inc(pc_q);
                state_d   = ST_FETCH;
              end
            end
          end
          ST_HOLD: begin
            if (!bus.stall) begin
              ifid_instr = hold_q;
              ifid_load  = 1'b1;
              pc_d       = pc_inc(pc_q);
              state_d    = ST_FETCH;
            end
          end
          ST_DROP: begin
            if (bus.imem_valid) state_d = ST_FETCH;
          end
          default: ;
        endcase
      end
    end
  end

  ifid_reg u_ifid (
    .clk       (clk),
    .rst_n     (rst),
    .load_i    (ifid_load),
    .flush_i   (ifid_flush),
    .instr_i   (ifid_instr),
    .pc_plus2_i(pc_inc(pc_q)),
    .ifid_o    (ifid)
  );

  // request is gated by reset so nothing is issued while rst is held low
  assign bus.imem_req     = req_c & rst;
  assign bus.imem_addr    = pc_q;
  assign bus.instr_out    = ifid.instr;
  assign bus.I_op         = ifid.instr[OPCODE_MSB:OPCODE_LSB];
  assign bus.func         = ifid.instr[FUNC_MSB:FUNC_LSB];
  assign bus.pc_plus2_out = ifid.pc_plus2;
  assign bus.valid_out    = ifid.valid;
  assign bus.halted       = halted_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: transaction-level model plus directed and random stimulus.
module tb_fetch_stage;
  import fetch_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fetch_if bus();

  fetch_stage #(.RESET_PC(16'h0000)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  // model: pending fetch / discard flag / one-entry stall buffer / IF/ID contents
  logic [15:0] m_pc, m_instr, m_pc2, m_buf;
  bit          m_valid, m_halted, m_pend, m_drop, m_buf_full;

  int          mem_cnt  = 0;
  logic [15:0] mem_data = 16'h0;
  int          lat      = 1;
  bit          rand_lat = 1'b0;
  bit          stray    = 1'b0;
  logic [15:0] dq[$];

  function automatic logic [15:0] rom(input logic [15:0] a);
    return 16'((a ^ 16'h5A5A) + {a[7:0], a[15:8]});
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 16'h0000; m_instr = 16'h0800; m_pc2 = 16'h0; m_valid = 0;
    m_halted = 0; m_pend = 0; m_drop = 0; m_buf_full = 0; m_buf = 16'h0;
  endtask

  task automatic check_cycle();
    logic [15:0] e_instr, e_pc2, e_addr;
    bit e_valid, e_halted, e_req, hg;
    if (!rst) begin
      e_instr = 16'h0800; e_pc2 = 16'h0; e_addr = 16'h0;
      e_valid = 0; e_halted = 0; e_req = 0;
    end else begin
      hg = bus.halt & m_valid & !bus.redirect_en;
      e_req = !m_halted && !m_pend && !m_buf_full && !bus.redirect_en && !hg;
      e_instr = m_instr; e_pc2 = m_pc2; e_addr = m_pc;
      e_valid = m_valid; e_halted = m_halted;
    end
    chk("imem_req",     32'(bus.imem_req),     32'(e_req));
    chk("imem_addr",    32'(bus.imem_addr),    32'(e_addr));
    chk("instr_out",    32'(bus.instr_out),    32'(e_instr));
    chk("pc_plus2_out", 32'(bus.pc_plus2_out), 32'(e_pc2));
    chk("valid_out",    32'(bus.valid_out),    32'(e_valid));
    chk("halted",       32'(bus.halted),       32'(e_halted));
    chk("I_op",         32'(bus.I_op),         32'(e_instr[15:11]));
    chk("func",         32'(bus.func),         32'(e_instr[1:0]));
  endtask

  task automatic deliver(input logic [15:0] d);
    m_instr = d; m_pc2 = 16'(m_pc + 16'd2); m_valid = 1; m_pc = 16'(m_pc + 16'd2);
  endtask

  task automatic step();
    bit hg, iss;
    if (!rst) begin
      model_reset();
      mem_cnt = 0;
    end else if (!m_halted) begin
      hg  = bus.halt & m_valid & !bus.redirect_en;
      iss = !m_pend && !m_buf_full && !bus.redirect_en && !hg;
      if (bus.redirect_en) begin
        m_pc = bus.redirect_pc;
        m_instr = 16'h0800; m_pc2 = 16'h0; m_valid = 0; m_buf_full = 0;
        if (m_pend && !bus.imem_valid) m_drop = 1;
        else begin m_pend = 0; m_drop = 0; end
      end else if (hg) begin
        m_halted = 1;
        if (!bus.stall) begin m_instr = 16'h0800; m_pc2 = 16'h0; m_valid = 0; end
      end else if (iss) begin
        m_pend = 1; m_drop = 0;
        if (rand_lat) lat = int'($urandom_range(1, 4));
        mem_cnt  = lat;
        mem_data = (dq.size() > 0) ? dq.pop_front() : rom(m_pc);
      end else if (m_pend && bus.imem_valid) begin
        m_pend = 0;
        if (m_drop) m_drop = 0;
        else if (!bus.stall) deliver(bus.imem_rdata);
        else begin m_buf = bus.imem_rdata; m_buf_full = 1; end
      end else if (m_buf_full && !bus.stall) begin
        m_buf_full = 0;
        deliver(m_buf);
      end
    end
  endtask

  task automatic mem_update();
    bus.imem_valid = 1'b0;
    bus.imem_rdata = 16'($urandom);
    if (stray) begin
      bus.imem_valid = 1'b1; bus.imem_rdata = 16'hDEAD; stray = 0;
    end else if (mem_cnt > 0) begin
      mem_cnt--;
      if (mem_cnt == 0) begin bus.imem_valid = 1'b1; bus.imem_rdata = mem_data; end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_cycle();
    step();
    @(posedge clk);
    #1;
    mem_update();
  endtask

  initial begin
    bus.stall = 0; bus.redirect_en = 0; bus.redirect_pc = 16'h0; bus.halt = 0;
    bus.imem_valid = 0; bus.imem_rdata = 16'h0;
    model_reset();

    // reset and two back-to-back 1-cycle fetches
    tick(); tick();
    chk("rst_instr", 32'(bus.instr_out), 32'h0800);
    chk("rst_valid", 32'(bus.valid_out), 32'h0);
    chk("rst_req",   32'(bus.imem_req),  32'h0);
    dq.push_back(16'h4001); dq.push_back(16'hC123); lat = 1;
    rst = 1; #1;
    chk("first_req",  32'(bus.imem_req),  32'h1);
    chk("first_addr", 32'(bus.imem_addr), 32'h0000);
    tick(); tick();
    chk("f1_instr", 32'(bus.instr_out),    32'h4001);
    chk("f1_pc2",   32'(bus.pc_plus2_out), 32'h0002);
    chk("f1_valid", 32'(bus.valid_out),    32'h1);
    chk("f2_addr",  32'(bus.imem_addr),    32'h0002);
    tick(); tick();
    chk("f2_instr", 32'(bus.instr_out),    32'hC123);
    chk("f2_pc2",   32'(bus.pc_plus2_out), 32'h0004);

    // stall across the response: data parked, IF/ID held
    dq.push_back(16'h9ABC); bus.stall = 1;
    tick(); tick(); tick();
    chk("hold_instr", 32'(bus.instr_out), 32'hC123);
    chk("hold_req",   32'(bus.imem_req),  32'h0);
    bus.stall = 0;
    tick();
    chk("unhold_instr", 32'(bus.instr_out),    32'h9ABC);
    chk("unhold_pc2",   32'(bus.pc_plus2_out), 32'h0006);
    chk("unhold_addr",  32'(bus.imem_addr),    32'h0006);

    // redirect while waiting on a 3-cycle memory
    lat = 3;
    tick();
    bus.redirect_en = 1; bus.redirect_pc = 16'h0100; #1;
    chk("redir_req", 32'(bus.imem_req), 32'h0);
    tick();
    bus.redirect_en = 0;
    chk("redir_instr", 32'(bus.instr_out), 32'h0800);
    chk("redir_valid", 32'(bus.valid_out), 32'h0);
    tick(); tick();
    #1;
    chk("drop_refetch_req",  32'(bus.imem_req),  32'h1);
    chk("drop_refetch_addr", 32'(bus.imem_addr), 32'h0100);
    lat = 1;

    // PC wrap at 0xFFFE
    bus.redirect_en = 1; bus.redirect_pc = 16'hFFFE;
    tick();
    bus.redirect_en = 0; dq.push_back(16'h1234);
    tick(); tick();
    chk("wrap_pc2",  32'(bus.pc_plus2_out), 32'h0000);
    chk("wrap_addr", 32'(bus.imem_addr),    32'h0000);

    // halt together with redirect: redirect wins
    bus.halt = 1; bus.redirect_en = 1; bus.redirect_pc = 16'h0200;
    tick();
    bus.halt = 0; bus.redirect_en = 0; #1;
    chk("hr_halted", 32'(bus.halted),    32'h0);
    chk("hr_addr",   32'(bus.imem_addr), 32'h0200);
    chk("hr_req",    32'(bus.imem_req),  32'h1);

    // halt on a valid 0x0000, then stray responses are ignored
    dq.push_back(16'h0000);
    tick(); tick();
    bus.halt = 1;
    tick();
    bus.halt = 0;
    chk("halt_flag", 32'(bus.halted), 32'h1);
    for (int i = 0; i < 20; i++) begin
      if (i == 5) stray = 1;
      tick();
      chk("halt_req", 32'(bus.imem_req), 32'h0);
    end
    chk("halt_addr", 32'(bus.imem_addr), 32'h0202);

    // async reset in the middle of a WAIT
    rst = 0; tick(); rst = 1;
    dq.push_back(16'hABCD); lat = 1;
    tick(); tick();
    lat = 4;
    tick();
    #2; rst = 0; #1;
    chk("arst_instr", 32'(bus.instr_out), 32'h0800);
    chk("arst_valid", 32'(bus.valid_out), 32'h0);
    chk("arst_addr",  32'(bus.imem_addr), 32'h0000);
    chk("arst_req",   32'(bus.imem_req),  32'h0);
    tick();

    // randomized traffic with periodic resets
    rand_lat = 1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      rst = (cyc % 500 == 0) ? 1'b0 : 1'b1;
      bus.stall       = ($urandom_range(0, 99) < 30);
      bus.redirect_en = ($urandom_range(0, 99) < 7);
      bus.redirect_pc = 16'($urandom) & 16'hFFFE;
      bus.halt        = ($urandom_range(0, 999) < 3);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
